vacc_sequencer: RTL and testbench
=================================

Name: vacc_sequencer

Overview:
- Controller that sequences the vector accumulator through integration cycles.
- Gates the PPS-aligned sync into the accumulator once after arming, then issues one trigger per integration.
- Tracks each drain burst on the accumulator's write strobe, counts completed dumps and stops after a programmed number, or runs continuously.
- Flags drains that start while the downstream reader is still busy with the previous dump.

Parameters:
- VECTOR_WIDTH, 11, log2 of channels per dump; sizes the vacc_addr input.
- COUNT_WIDTH, 32, width of n_dumps and dump_count.
- TIMEOUT_CYCLES, 2**26, watchdog limit in ce-qualified cycles (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  clock enable; all state advances only when ce=1
- arm  in  1  host pulse: start a run
- disarm  in  1  host pulse: abort the run
- n_dumps  in  COUNT_WIDTH  dumps per run; 0 = continuous; sampled on arm
- sync_in  in  1  PPS-aligned sync pulse
- reader_busy  in  1  downstream still consuming the previous dump
- vacc_we  in  1  accumulator output write strobe
- vacc_addr  in  VECTOR_WIDTH  accumulator output address (monitor only)
- vacc_sync  out  1  sync to the accumulator
- vacc_trig  out  1  trigger to the accumulator
- dump_done  out  1  one-cycle pulse at the end of each drain
- dump_count  out  COUNT_WIDTH  dumps completed this run
- busy  out  1  high in any state other than IDLE
- overflow  out  1  sticky: a drain started while reader_busy=1
- timeout  out  1  sticky watchdog flag (optional feature only; otherwise tied to 0)

Behaviour:
- Reset: state=IDLE; every output 0, including dump_count.
- States: IDLE, WAIT_SYNC, TRIG, RUN, DRAIN.
- Every output is registered, so each output lags its cause by one cycle.
- IDLE:
  - arm -> WAIT_SYNC; latch n_dumps; clear dump_count, overflow and timeout.
  - arm is ignored in every state other than IDLE.
- WAIT_SYNC:
  - sync_in forwarded to vacc_sync as a single-cycle pulse on the next cycle; then -> TRIG.
  - vacc_sync fires only once per arm; sync_in is ignored in all other states.
- TRIG: vacc_trig=1 for exactly one ce cycle -> RUN.
- RUN:
  - rising edge of vacc_we -> DRAIN.
  - If reader_busy=1 on that same cycle, set overflow; the drain is still tracked normally.
- DRAIN: first cycle with vacc_we=0 after it was high is the end of the drain:
  - pulse dump_done and increment dump_count.
  - If latched n_dumps != 0 and the new count == n_dumps -> IDLE.
  - Otherwise -> TRIG, so the next integration is re-triggered 1 cycle after dump_done.
- dump_count saturates at all-ones; it does not wrap.
- vacc_addr is used only as a check: it must equal 0 at the rising edge of vacc_we. A mismatch sets overflow (misalignment is treated as a lost frame).
- disarm:
  - In WAIT_SYNC, TRIG or RUN: -> IDLE at once.
  - In DRAIN: the current drain finishes (dump_done still fires), then -> IDLE.
  - disarm and arm together in IDLE: disarm wins, stay IDLE.
- ce=0: state, counters and strobes hold; vacc_trig and vacc_sync are not emitted.
- rst mid-run: immediate IDLE, outputs cleared. The accumulator must share the same rst.

Optional Feature:
- Macro: VACC_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in RUN and DRAIN and reloads on every edge of vacc_we.
  - On reaching TIMEOUT_CYCLES: set timeout and go to IDLE.
- Not defined: no counter is built; timeout is constant 0.

Decomposition:
- Shared package vacc_pkg:
  - seq_state_t enum for the five states.
  - VACC_VECTOR_WIDTH default constant.
- One sub-module, edge_detect: registered rise/fall detector with ce. Instantiated on vacc_we and on sync_in.

Test Plan:
- arm, n_dumps=2, VECTOR_WIDTH=3, with a behavioural accumulator model:
  - one vacc_sync after the sync_in pulse;
  - vacc_trig twice;
  - dump_done twice; dump_count ends at 2; busy then 0.
- n_dumps=0, run 5 drains, then disarm during DRAIN:
  - the drain completes;
  - dump_count=5 on the final dump_done, then IDLE.
- reader_busy=1 at the vacc_we rising edge of the second drain: overflow=1 and stays 1 until the next arm; dump_count still increments.
- vacc_addr=3 at a vacc_we rising edge: overflow=1.
- ce toggling 1/0 every cycle throughout the n_dumps=2 scenario: same sequence of trig and done pulses, stretched in time; no duplicated pulses.
- With VACC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: arm, no vacc_we ever arrives -> timeout=1 and busy=0 at cycle 16 after entering RUN. rst asserted in RUN -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/vacc_pkg.sv
// rtl/vacc_pkg.sv - shared types and defaults for the vector accumulator sequencer
package vacc_pkg;

   // log2 of channels per dump for the default accumulator build
   localparam int VACC_VECTOR_WIDTH = 11;

   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_WAIT_SYNC = 3'd1,
      SEQ_TRIG      = 3'd2,
      SEQ_RUN       = 3'd3,
      SEQ_DRAIN     = 3'd4
   } seq_state_t;

endpackage

// File: rtl/vacc_sequencer_if.sv
// rtl/vacc_sequencer_if.sv - sequencer <-> vector accumulator control/monitor link
interface vacc_sequencer_if
   import vacc_pkg::*;
#(
   parameter int VECTOR_WIDTH = VACC_VECTOR_WIDTH
);
   logic                    vacc_sync;
   logic                    vacc_trig;
   logic                    vacc_we;
   logic [VECTOR_WIDTH-1:0] vacc_addr;

   modport master (
      output vacc_sync,
      output vacc_trig,
      input  vacc_we,
      input  vacc_addr
   );

   modport slave (
      input  vacc_sync,
      input  vacc_trig,
      output vacc_we,
      output vacc_addr
   );
endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rise/fall detector against a ce-qualified registered copy
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic d_q;

   // previous value only advances on enabled cycles so edges are seen in ce time
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
      end else if (ce) begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;
   assign fall = ~d & d_q;
endmodule

// File: rtl/vacc_sequencer.sv
// rtl/vacc_sequencer.sv - integration sequencer for the vector accumulator; VACC_SEQ_TIMEOUT_EN adds a watchdog
module vacc_sequencer
   import vacc_pkg::*;
#(
   parameter int VECTOR_WIDTH   = VACC_VECTOR_WIDTH,
   parameter int COUNT_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 2**26
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   arm,
   input  logic                   disarm,
   input  logic [COUNT_WIDTH-1:0] n_dumps,
   input  logic                   sync_in,
   input  logic                   reader_busy,
   vacc_sequencer_if.master       acc,
   output logic                   dump_done,
   output logic [COUNT_WIDTH-1:0] dump_count,
   output logic                   busy,
   output logic                   overflow,
   output logic                   timeout
);
   localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
   localparam logic [2:0] ST_WAIT_SYNC = SEQ_WAIT_SYNC;
   localparam logic [2:0] ST_TRIG      = SEQ_TRIG;
   localparam logic [2:0] ST_RUN       = SEQ_RUN;
   localparam logic [2:0] ST_DRAIN     = SEQ_DRAIN;

   logic [2:0]              state_q;
   logic [2:0]              state_d;
   logic [COUNT_WIDTH-1:0]  n_dumps_q;
   logic [COUNT_WIDTH-1:0]  dump_count_q;
   logic [COUNT_WIDTH-1:0]  count_inc;
   logic                    disarm_pend_q;
   logic                    sync_q;
   logic                    trig_q;
   logic                    done_q;
   logic                    busy_q;
   logic                    overflow_q;
   logic [VECTOR_WIDTH-1:0] addr_mon;
   logic                    we_rise;
   logic                    we_fall;
   logic                    sync_rise;
   logic                    sync_fall_unused;
   logic                    arm_go;
   logic                    drain_start;
   logic                    drain_end;
   logic                    last_dump;
   logic                    wd_expire;

   edge_detect u_we_edge (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .d    (acc.vacc_we),
      .rise (we_rise),
      .fall (we_fall)
   );

   edge_detect u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .d    (sync_in),
      .rise (sync_rise),
      .fall (sync_fall_unused)
   );

   assign addr_mon    = acc.vacc_addr;
   assign arm_go      = (state_q == ST_IDLE) && arm && !disarm;
   assign drain_start = (state_q == ST_RUN) && we_rise;
   assign drain_end   = (state_q == ST_DRAIN) && we_fall;
   // the count sticks at all-ones rather than wrapping back to zero
   assign count_inc   = (dump_count_q == '1) ? dump_count_q : dump_count_q + COUNT_WIDTH'(1);
   assign last_dump   = (n_dumps_q != '0) && (count_inc == n_dumps_q);

   // next-state decode; a disarm seen during a drain is honoured when the drain ends
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (arm_go) state_d = ST_WAIT_SYNC;
         ST_WAIT_SYNC: if (disarm) state_d = ST_IDLE;
                       else if (sync_rise) state_d = ST_TRIG;
         ST_TRIG:      state_d = disarm ? ST_IDLE : ST_RUN;
         ST_RUN:       if (disarm) state_d = ST_IDLE;
                       else if (we_rise) state_d = ST_DRAIN;
         ST_DRAIN:     if (drain_end) begin
                          state_d = (last_dump || disarm_pend_q || disarm) ? ST_IDLE : ST_TRIG;
                       end
         default:      state_d = ST_IDLE;
      endcase
      if (wd_expire) state_d = ST_IDLE;
   end

   // registered state, counters and strobes; sync/trig are never emitted on ce=0 cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         n_dumps_q     <= '0;
         dump_count_q  <= '0;
         disarm_pend_q <= 1'b0;
         sync_q        <= 1'b0;
         trig_q        <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         overflow_q    <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
         sync_q  <= (state_q == ST_WAIT_SYNC) && sync_rise && !disarm;
         trig_q  <= (state_q == ST_TRIG) && !disarm;
         done_q  <= drain_end;

         if (arm_go) begin
            n_dumps_q    <= n_dumps;
            dump_count_q <= '0;
         end else if (drain_end) begin
            dump_count_q <= count_inc;
         end

         // a busy reader or a drain not starting at address 0 means a lost frame
         if (arm_go) begin
            overflow_q <= 1'b0;
         end else if (drain_start && (reader_busy || addr_mon != '0)) begin
            overflow_q <= 1'b1;
         end

         if (state_d == ST_IDLE) begin
            disarm_pend_q <= 1'b0;
         end else if (state_q == ST_DRAIN && disarm) begin
            disarm_pend_q <= 1'b1;
         end
      end else begin
         sync_q <= 1'b0;
         trig_q <= 1'b0;
      end
   end

`ifdef VACC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WD_W-1:0] wd_q;
   logic            timeout_q;
   logic            wd_active;

   assign wd_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign wd_expire = wd_active && !(we_rise || we_fall) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // watchdog counts enabled cycles in RUN/DRAIN and restarts on every write-strobe edge
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (ce) begin
         if (wd_active && !(we_rise || we_fall) && !wd_expire) begin
            wd_q <= wd_q + WD_W'(1);
         end else begin
            wd_q <= '0;
         end
         if (arm_go) begin
            timeout_q <= 1'b0;
         end else if (wd_expire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout = timeout_q;
`else
   // keeps the watchdog limit referenced in builds without the watchdog
   localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

   assign wd_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

   assign acc.vacc_sync = sync_q;
   assign acc.vacc_trig = trig_q;
   assign dump_done     = done_q;
   assign dump_count    = dump_count_q;
   assign busy          = busy_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_vacc_sequencer.sv
// tb/tb_vacc_sequencer.sv - directed self-checking bench for vacc_sequencer
module tb_vacc_sequencer;
   localparam int VW = 3;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic          arm;
   logic          disarm;
   logic [CW-1:0] n_dumps;
   logic          sync_in;
   logic          reader_busy;
   logic          dump_done;
   logic [CW-1:0] dump_count;
   logic          busy;
   logic          overflow;
   logic          timeout;

   vacc_sequencer_if #(.VECTOR_WIDTH(VW)) acc ();

   vacc_sequencer #(
      .VECTOR_WIDTH   (VW),
      .COUNT_WIDTH    (CW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .arm         (arm),
      .disarm      (disarm),
      .n_dumps     (n_dumps),
      .sync_in     (sync_in),
      .reader_busy (reader_busy),
      .acc         (acc),
      .dump_done   (dump_done),
      .dump_count  (dump_count),
      .busy        (busy),
      .overflow    (overflow),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int m_phase, m_cnt, m_drains;
   int busy_drain, bad_drain, disarm_drain;
   bit m_off, m_disarm, h_disarm, trig_seen, last_ce, ce_tog;
   int cyc_n, n_sync, n_trig, n_done, last_done_cyc, last_done_cnt, gap, trig_cyc;
   bit p_sync, p_trig, p_done;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      m_phase = 0; m_cnt = 0; m_drains = 0;
      busy_drain = -1; bad_drain = -1; disarm_drain = -1;
      m_off = 0; m_disarm = 0; trig_seen = 0;
      reader_busy = 0; acc.vacc_we = 0; acc.vacc_addr = '0;
   endtask

   task automatic clr_stats();
      n_sync = 0; n_trig = 0; n_done = 0; gap = -1;
      last_done_cyc = 0; last_done_cnt = 0; trig_cyc = 0;
      p_sync = acc.vacc_sync; p_trig = acc.vacc_trig; p_done = dump_done;
   endtask

   // behavioural accumulator: 3 integration steps after a trigger, then an 8-word drain
   task automatic model_step();
      m_disarm = 0; reader_busy = 0; acc.vacc_we = 0;
      if (!m_off) begin
         case (m_phase)
            0: if (trig_seen) begin trig_seen = 0; m_phase = 1; m_cnt = 3; end
            1: begin
               m_cnt--;
               if (m_cnt == 0) begin m_phase = 2; m_drains++; end
            end
            default: begin
               acc.vacc_we   = 1;
               acc.vacc_addr = 3'(m_cnt + ((m_drains == bad_drain) ? 3 : 0));
               reader_busy   = (m_drains == busy_drain);
               m_disarm      = (m_drains == disarm_drain) && (m_cnt == 4);
               m_cnt++;
               if (m_cnt == 8) m_phase = 0;
            end
         endcase
      end
   endtask

   task automatic sample();
      cyc_n++;
      if (acc.vacc_sync && !p_sync) n_sync++;
      if (acc.vacc_trig && !p_trig) begin
         n_trig++; trig_seen = 1; trig_cyc = cyc_n;
         if (n_done == 1 && gap < 0) gap = cyc_n - last_done_cyc;
      end
      if (dump_done && !p_done) begin
         n_done++; last_done_cyc = cyc_n; last_done_cnt = dump_count;
      end
      p_sync = acc.vacc_sync; p_trig = acc.vacc_trig; p_done = dump_done;
   endtask

   task automatic cyc();
      ce = ce_tog ? ~ce : 1'b1;
      last_ce = ce;
      if (ce) model_step();
      disarm = h_disarm | m_disarm;
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic pulse_arm();
      arm = 1;
      do cyc(); while (!last_ce);
      arm = 0;
   endtask

   task automatic pulse_sync();
      sync_in = 1;
      do cyc(); while (!last_ce);
      sync_in = 0;
   endtask

   task automatic run_idle(input int budget, input string tag);
      int used = budget;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (!busy) begin used = i; break; end
      end
      check_val(tag, 32'(used < budget), 1);
   endtask

   initial begin
      rst = 1; ce = 1; arm = 0; disarm = 0; h_disarm = 0; n_dumps = '0; sync_in = 0;
      ce_tog = 0; cyc_n = 0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_sync", acc.vacc_sync, 0);
      check_val("rst_trig", acc.vacc_trig, 0);
      check_val("rst_done", dump_done, 0);
      check_val("rst_count", dump_count, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_timeout", timeout, 0);
      rst = 0;

      // n_dumps=2, full-rate ce, with a stray second sync pulse mid-run
      reset_model(); clr_stats();
      n_dumps = 2;
      pulse_arm();
      check_val("s1_busy_armed", busy, 1);
      pulse_sync();
      repeat (4) cyc();
      pulse_sync();
      run_idle(400, "s1_finish");
      check_val("s1_syncs", n_sync, 1);
      check_val("s1_trigs", n_trig, 2);
      check_val("s1_dones", n_done, 2);
      check_val("s1_count", dump_count, 2);
      check_val("s1_last_done_cnt", last_done_cnt, 2);
      check_val("s1_retrig_gap", gap, 1);
      check_val("s1_ovf", overflow, 0);

      // same run with ce toggling every cycle
      reset_model(); clr_stats();
      ce_tog = 1;
      pulse_arm();
      pulse_sync();
      run_idle(400, "s2_finish");
      ce_tog = 0;
      check_val("s2_syncs", n_sync, 1);
      check_val("s2_trigs", n_trig, 2);
      check_val("s2_dones", n_done, 2);
      check_val("s2_count", dump_count, 2);

      // continuous run, busy reader on drain 2, disarm mid drain 5
      reset_model(); clr_stats();
      busy_drain = 2; disarm_drain = 5; n_dumps = 0;
      pulse_arm();
      pulse_sync();
      run_idle(600, "s3_finish");
      check_val("s3_dones", n_done, 5);
      check_val("s3_trigs", n_trig, 5);
      check_val("s3_last_done_cnt", last_done_cnt, 5);
      check_val("s3_count", dump_count, 5);
      repeat (3) cyc();
      check_val("s3_ovf_sticky", overflow, 1);
      check_val("s3_timeout", timeout, 0);

      // misaligned drain: address 3 at the write-strobe rise
      reset_model(); clr_stats();
      bad_drain = 1; n_dumps = 1;
      pulse_arm();
      check_val("s4_ovf_cleared", overflow, 0);
      check_val("s4_count_cleared", dump_count, 0);
      pulse_sync();
      run_idle(200, "s4_finish");
      check_val("s4_dones", n_done, 1);
      check_val("s4_count", dump_count, 1);
      check_val("s4_ovf", overflow, 1);

      // arm and disarm together in IDLE: stay idle, nothing cleared
      arm = 1; h_disarm = 1;
      cyc();
      arm = 0; h_disarm = 0;
      cyc();
      check_val("s5_busy", busy, 0);
      check_val("s5_count_kept", dump_count, 1);
      check_val("s5_ovf_kept", overflow, 1);

      // reset in RUN after one dump with an overflow
      reset_model(); clr_stats();
      busy_drain = 1; n_dumps = 0;
      pulse_arm();
      pulse_sync();
      for (int i = 0; i < 200 && n_done < 1; i++) cyc();
      check_val("s6_first_done", n_done, 1);
      repeat (3) cyc();
      check_val("s6_pre_busy", busy, 1);
      check_val("s6_pre_ovf", overflow, 1);
      rst = 1;
      cyc();
      check_val("s6_rst_busy", busy, 0);
      check_val("s6_rst_count", dump_count, 0);
      check_val("s6_rst_ovf", overflow, 0);
      check_val("s6_rst_done", dump_done, 0);
      check_val("s6_rst_trig", acc.vacc_trig, 0);
      check_val("s6_rst_sync", acc.vacc_sync, 0);
      rst = 0;

`ifdef VACC_SEQ_TIMEOUT_EN
      // no write strobe ever arrives: watchdog fires 16 cycles after entering RUN
      reset_model(); clr_stats();
      m_off = 1; n_dumps = 0;
      pulse_arm();
      pulse_sync();
      for (int i = 0; i < 20 && n_trig < 1; i++) cyc();
      check_val("s7_trig", n_trig, 1);
      for (int i = 0; i < 40 && !timeout; i++) cyc();
      check_val("s7_timeout", timeout, 1);
      check_val("s7_latency", cyc_n - trig_cyc, 16);
      check_val("s7_busy", busy, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1);
   end
endmodule
